free_list: RTL

- Physical-register free list feeding the rename/dispatch stage.
- Supplies up to two new PRF specifiers per cycle; these are the instr0/instr1 rd_new_prf values consumed by the register map table.
- Reclaims stale PRFs at ROB commit.
- Returns speculatively allocated PRFs on branch recovery, by restoring per-checkpoint head pointers or by walking the head back.
- Checkpoint indexing matches the map-table copy scheme: ROB tag bits [5:3], copy when tag bits [2:0]==0.

---
 rtl/free_list.sv | 123 ++++++++++++
 1 files changed

// File: rtl/free_list.sv
// Circular free list of physical register specifiers: two-wide allocation at head,
// two-wide reclaim at tail, head recovery via checkpoints or walk-back.
module free_list #(
   parameter int PRF_NUM  = 64,
   parameter int ARF_NUM  = 32,
   parameter int PRF_W    = 6,
   parameter int DEPTH    = 32,
   parameter int CKPT_NUM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc0_req,
   input  logic             alloc1_req,
   output logic [PRF_W-1:0] alloc0_prf,
   output logic [PRF_W-1:0] alloc1_prf,
   output logic             alloc_stall,
   input  logic [5:0]       instr0_rob_tag,
   input  logic [5:0]       instr1_rob_tag,
   input  logic             instr0_valid,
   input  logic             instr1_valid,
   input  logic             release0_valid,
   input  logic [PRF_W-1:0] release0_prf,
   input  logic             release1_valid,
   input  logic [PRF_W-1:0] release1_prf,
   input  logic             recovery_flush,
   input  logic             recovery_no_copy,
   input  logic [5:0]       recovery_target_rob_tag,
   input  logic             recovery_mode,
   input  logic [1:0]       rollback_cnt,
   output logic [PRF_W-1:0] free_count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PRF_W-1:0] entry_reg [DEPTH];
   logic [PTR_W-1:0] ckpt_reg [CKPT_NUM];
   logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
   logic [PTR_W-1:0] head_plus1, tail_slot1;
   logic [PRF_W-1:0] count;
   logic [1:0]       need, rel_cnt;
   logic             rel0_en, rel1_en, restore, rename_fire;
   logic [2:0]       restore_idx;

   // Wrap bit makes tail - head distinguish full (DEPTH) from empty (0).
   assign count      = PRF_W'(tail_reg - head_reg);
   assign free_count = count;

   assign head_plus1  = head_reg + PTR_W'(1);
   assign alloc0_prf  = entry_reg[head_reg[IDX_W-1:0]];
   assign alloc1_prf  = alloc0_req ? entry_reg[head_plus1[IDX_W-1:0]] : alloc0_prf;
   assign need        = {1'b0, alloc0_req} + {1'b0, alloc1_req};
   assign alloc_stall = count < PRF_W'(need);

   assign restore     = recovery_flush && !recovery_no_copy;
   assign rename_fire = !alloc_stall && !recovery_flush && !recovery_mode;
   // A mispredicted instruction that is not itself a group leader restores the next group's copy.
   assign restore_idx = recovery_target_rob_tag[5:3]
                        + {2'b00, (recovery_target_rob_tag[2:0] != 3'd0)};

   assign rel0_en    = release0_valid && (release0_prf != '0);
   assign rel1_en    = release1_valid && (release1_prf != '0);
   assign rel_cnt    = {1'b0, rel0_en} + {1'b0, rel1_en};
   assign tail_slot1 = tail_reg + PTR_W'(rel0_en);
   assign tail_next  = tail_reg + PTR_W'(rel_cnt);

   always_comb begin
      head_next = head_reg;
      if (restore) begin
         head_next = ckpt_reg[restore_idx];
      end else if (recovery_flush) begin
         head_next = head_reg;
      end else if (recovery_mode) begin
         head_next = head_reg - PTR_W'(rollback_cnt);
      end else if (!alloc_stall) begin
         head_next = head_reg + PTR_W'(need);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg <= '0;
         tail_reg <= PTR_W'(DEPTH);
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_reg[i] <= PRF_W'(ARF_NUM + i);
         end
      end else begin
         if (rel0_en) entry_reg[tail_reg[IDX_W-1:0]] <= release0_prf;
         if (rel1_en) entry_reg[tail_slot1[IDX_W-1:0]] <= release1_prf;
      end
   end

   // instr1's checkpoint must already account for instr0's allocation this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CKPT_NUM; i++) begin
            ckpt_reg[i] <= '0;
         end
      end else if (rename_fire) begin
         if (instr0_valid && instr0_rob_tag[2:0] == 3'd0) begin
            ckpt_reg[instr0_rob_tag[5:3]] <= head_reg;
         end else if (instr1_valid && instr1_rob_tag[2:0] == 3'd0) begin
            ckpt_reg[instr1_rob_tag[5:3]] <= head_reg + PTR_W'(alloc0_req);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (int'(count) + int'(rel_cnt) <= DEPTH)
            else $error("free_list: release overflows list capacity");
         assert (!rel0_en || int'(release0_prf) < PRF_NUM)
            else $error("free_list: release0_prf out of range");
      end
   end
endmodule
